// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
// The ALU_* codes are also used by the shared 32-bit ALU.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BEQ
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    FUNC
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's abstract ALU operation plus funct fields to an alu_control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ADD: alu_control = ALU_ADD;
      SUB: alu_control = ALU_SUB;
      FUNC: begin
        case (funct3)
          // funct7b5 only means sub for R-type; addi reuses that bit as immediate
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath: sequences each
// instruction and drives mux selects, enables and the ALU operation.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_t state_reg, state_next;
  aluop_t aluop;
  logic   pc_update, branch, illegal_next;
  logic   mem_write_next, ir_write_next, reg_write_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = FETCH;
    adr_src        = ADR_PC;
    mem_write_next = 1'b0;
    ir_write_next  = 1'b0;
    reg_write_next = 1'b0;
    result_src     = RES_ALUOUT;
    alu_src_a      = SRCA_PC;
    alu_src_b      = SRCB_RS2;
    aluop          = ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    illegal_next   = 1'b0;
    case (state_reg)
      FETCH: begin
        ir_write_next = 1'b1;
        alu_src_b     = SRCB_FOUR;
        result_src    = RES_ALURESULT;
        pc_update     = 1'b1;
        state_next    = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      illegal_next = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = ADR_ALUOUT;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src     = RES_DATA;
        reg_write_next = 1'b1;
      end
      MEMWRITE: begin
        adr_src        = ADR_ALUOUT;
        mem_write_next = 1'b1;
      end
      EXECR: begin
        alu_src_a  = SRCA_RS1;
        aluop      = FUNC;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        aluop      = FUNC;
        state_next = ALUWB;
      end
      JAL: begin
        // OldPC + 4 becomes the link value while the target is loaded into PC
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      ALUWB: reg_write_next = 1'b1;
      BEQ: begin
        alu_src_a = SRCA_RS1;
        aluop     = SUB;
        branch    = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Write enables are gated by rst_n so nothing is written while reset is held
  assign pc_write      = rst_n & (pc_update | (branch & zero));
  assign mem_write     = rst_n & mem_write_next;
  assign ir_write      = rst_n & ir_write_next;
  assign reg_write     = rst_n & reg_write_next;
  assign illegal_instr = rst_n & illegal_next;

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
      OP_JAL:      imm_src = IMM_J;
      default:     imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op5         (opcode[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RISC-V datapath: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the shared ALU's `alu_control` and mux selects. It consumes the ALU's `zero` flag to resolve `beq`. It sits between the instruction register and the datapath, alongside the shared 32-bit ALU.

## Interface

No parameters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction register and OldPC enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux select, 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A select, 00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b` out 2: ALU B select, 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `imm_src` out 2: immediate format select.
- `alu_control` out 3: ALU operation select.
- `illegal_instr` out 1: unsupported opcode seen in DECODE.

## Operation

- **State register.** States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ. Outputs are combinational from the state only, except `pc_write` and `illegal_instr`.
- **FETCH.** adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, aluop=ADD, result_src=10, pc_update=1. Next state: DECODE.
- **DECODE.** alu_src_a=01, alu_src_b=01, aluop=ADD. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 (R-type) -> EXECR
  - 0010011 (I-type) -> EXECI
  - 1101111 (jal) -> JAL
  - 1100011 (beq) -> BEQ
  - any other opcode -> FETCH, with illegal_instr=1 for that cycle.
- **MEMADR.** alu_src_a=10, alu_src_b=01, aluop=ADD. Next state: MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD.** adr_src=1, result_src=00. Next state: MEMWB.
- **MEMWB.** result_src=01, reg_write=1. Next state: FETCH.
- **MEMWRITE.** adr_src=1, result_src=00, mem_write=1. Next state: FETCH.
- **EXECR.** alu_src_a=10, alu_src_b=00, aluop=FUNC. Next state: ALUWB.
- **EXECI.** alu_src_a=10, alu_src_b=01, aluop=FUNC. Next state: ALUWB.
- **JAL.** alu_src_a=01, alu_src_b=10, aluop=ADD, result_src=00, pc_update=1. Next state: ALUWB.
- **ALUWB.** result_src=00, reg_write=1. Next state: FETCH.
- **BEQ.** alu_src_a=10, alu_src_b=00, aluop=SUB, result_src=00, branch=1. Next state: FETCH.
- **Defaults.** Any output not listed for a state is 0.
- **pc_write** = pc_update | (branch & zero).
- **imm_src.** Combinational from opcode in every state: lw and I-type -> 00, sw -> 01, beq -> 10, jal -> 11, otherwise 00.
- **ALU decode.**
  - aluop ADD -> 000; SUB -> 001.
  - aluop FUNC, by funct3:
    - 000 -> 001 (sub) when opcode[5] and funct7b5 are both 1, else 000 (add)
    - 010 -> 101 (slt)
    - 110 -> 011 (or)
    - 111 -> 010 (and)
    - any other funct3 -> 000.

## Timing

- **Reset.** While rst_n=0 the state is FETCH, and pc_write, ir_write, mem_write, reg_write and illegal_instr are forced to 0. All other outputs take their FETCH values, so alu_control=000.
  - Reset deassertion: the first rising edge with rst_n=1 executes FETCH.
  - Reset mid-instruction: the state goes to FETCH immediately (asynchronously). No partial write occurs after rst_n falls.
- **Cycles per instruction.** lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- **Branch decision.** `zero` is sampled combinationally in BEQ only. A zero pulse in any other state has no effect.
- **Input stability.** opcode, funct3 and funct7b5 must be stable from DECODE until the instruction completes; the instruction register holds them.

## Structure

- **Package `riscv_ctrl_pkg`:**
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - aluop enum (ADD, SUB, FUNC)
  - alu_control codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101), shared with the ALU
  - mux-select constants.
- **Sub-module `alu_decoder`:** combinational; inputs aluop, funct3, opcode[5], funct7b5; output alu_control. The FSM, next-state logic and imm_src decode stay in the top module.

## Test plan

- **Reset during MEMWRITE.** Hold rst_n=0 during a sw in MEMWRITE -> mem_write drops to 0 at once and the state is FETCH. After release, ir_write=1 in the first cycle.
- **lw.** Opcode 0000011 -> state trace FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5, with result_src=01 and imm_src=00.
- **sub / slt.** R-type with funct3=000 and funct7b5=1 -> alu_control=001 in EXECR, then reg_write=1 in ALUWB. Repeat with funct3=010 -> alu_control=101.
- **addi with funct7b5=1.** I-type, funct3=000, funct7b5=1 -> alu_control=000, because opcode[5]=0 selects add.
- **beq.** beq with zero=1 -> pc_write=1 in the BEQ cycle with alu_control=001. Same with zero=0 -> pc_write=0. Both take 3 cycles back to FETCH.
- **Illegal opcode and jal.** Opcode 1110011 -> illegal_instr=1 in DECODE, then FETCH next cycle with no reg_write or mem_write. Opcode jal -> pc_write=1 in JAL, reg_write=1 in ALUWB, imm_src=11.
